// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, IR handshake to the
// control unit, and branch redirect / halt status.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_valid;
    logic [31:0]       IR;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              br_take;
    logic [ADDR_W-1:0] br_target;
    logic              halted;

    modport master (
        output mem_rd, mem_addr,
        input  mem_data, mem_valid,
        output IR, ir_pc, ir_valid,
        input  ir_ready,
        input  br_take, br_target,
        output halted
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_data, mem_valid,
        input  IR, ir_pc, ir_valid,
        output ir_ready,
        output br_take, br_target,
        input  halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, single-outstanding memory reads, 2-entry prefetch
// buffer driving IR, branch redirect with in-flight discard, and HALT stop.
module instr_fetch #(
    parameter int unsigned       ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          clr,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALT} state_t;

    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              discard_q, discard_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [31:0]       data_q [2];
    logic [31:0]       data_d [2];
    logic [ADDR_W-1:0] tag_q  [2];
    logic [ADDR_W-1:0] tag_d  [2];
    logic              push;
    logic              pop;
    logic              tail;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
            count_q    <= '0;
            head_q     <= 1'b0;
            data_q     <= '{default: '0};
            tag_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            head_q     <= head_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        count_d    = count_q;
        head_d     = head_q;
        data_d     = data_q;
        tag_d      = tag_q;
        push       = 1'b0;
        pop        = (count_q != 2'd0) && bus.ir_ready;
        tail       = head_q ^ count_q[0];

        case (state_q)
            S_FETCH: begin
                if (count_q != 2'd2) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_FETCH;
                    end else begin
                        push    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = (bus.mem_data[31:27] == OP_HALT) ? S_HALT : S_FETCH;
                    end
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase

        if (push) begin
            data_d[tail] = bus.mem_data;
            tag_d[tail]  = pc_q;
        end
        if (pop) head_d = ~head_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Redirect overrides everything above; a request still in flight is
        // marked for discard so its late response cannot land in the buffer.
        if (bus.br_take) begin
            count_d    = '0;
            pc_d       = bus.br_target;
            mem_rd_d   = 1'b0;
            mem_addr_d = mem_addr_q;
            if (state_q == S_WAIT && !bus.mem_valid) begin
                state_d   = S_WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = S_FETCH;
                discard_d = 1'b0;
            end
        end
    end

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.IR       = data_q[head_q];
    assign bus.ir_pc    = tag_q[head_q];
    assign bus.ir_valid = (count_q != 2'd0);
    assign bus.halted   = (state_q == S_HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: latency-programmable memory responder plus a
// scoreboard of expected {IR, ir_pc} words checked on each accepted handshake.
module tb_instr_fetch;
    localparam int unsigned AW = 9;

    logic clk = 1'b0;
    logic clr;

    instr_fetch_if #(.ADDR_W(AW)) bus ();

    instr_fetch #(.ADDR_W(AW), .RESET_PC(9'd0)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic        halt_en = 1'b0;
    logic [63:0] exp_q [$];

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        if (halt_en && a == 9'd3) return 32'hF800_0000;
        return 32'h0800_0000 + {23'd0, a};
    endfunction

    function automatic logic [63:0] ent(input logic [31:0] d, input logic [AW-1:0] a);
        return {d, 23'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Memory model: answers each mem_rd after lat cycles, independent of clr,
    // so a request cut off by reset still produces a stale response.
    initial begin
        int          pend_cnt;
        logic [AW-1:0] pend_addr;
        pend_cnt      = 0;
        pend_addr     = '0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_data  = word_at(pend_addr);
                end
            end
            if (bus.mem_rd === 1'b1) begin
                pend_addr = bus.mem_addr;
                pend_cnt  = lat;
            end
        end
    end

    always @(negedge clk) begin
        if (!clr && bus.ir_valid === 1'b1 && bus.ir_ready === 1'b1) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL sb_extra cyc=%0d observed IR=%h ir_pc=%h expected none", cyc, bus.IR, bus.ir_pc);
            end
            if (exp_q.size() > 0) chk("sb_word", ent(bus.IR, bus.ir_pc), exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk_rd(input logic exp_rd, input logic [AW-1:0] exp_addr);
        chk("mem_rd", 64'(bus.mem_rd), 64'(exp_rd));
        if (exp_rd) chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
    endtask

    task automatic chk_ir(input logic [31:0] d, input logic [AW-1:0] a);
        chk("ir_valid", 64'(bus.ir_valid), 64'd1);
        chk("ir_word", ent(bus.IR, bus.ir_pc), ent(d, a));
    endtask

    task automatic chk_empty();
        chk("ir_empty", 64'(bus.ir_valid), 64'd0);
    endtask

    task automatic chk_drain();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int hold);
        clr = 1'b1;
        #1;
        chk("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_ir_valid", 64'(bus.ir_valid), 64'd0);
        chk("rst_IR", 64'(bus.IR), 64'd0);
        chk("rst_ir_pc", 64'(bus.ir_pc), 64'd0);
        chk("rst_halted", 64'(bus.halted), 64'd0);
        repeat (hold) tick();
        clr = 1'b0;
        cyc = 0;
    endtask

    initial begin
        clr           = 1'b0;
        bus.ir_ready  = 1'b0;
        bus.br_take   = 1'b0;
        bus.br_target = '0;
        tick();

        // Sequential fetch, L=1
        lat = 1;
        bus.ir_ready = 1'b1;
        do_reset(5);
        exp_q.push_back(ent(word_at(9'd0), 9'd0));
        exp_q.push_back(ent(word_at(9'd1), 9'd1));
        chk_empty(); chk_rd(1'b0, 9'd0);
        run_to(1); chk_rd(1'b1, 9'd0);
        run_to(2); chk_rd(1'b0, 9'd0); chk_empty();
        run_to(3); chk_ir(32'h0800_0000, 9'd0);
        run_to(4); chk_rd(1'b1, 9'd1); chk_empty();
        run_to(6); chk_ir(32'h0800_0001, 9'd1);
        run_to(7); chk_rd(1'b1, 9'd2);
        chk_drain();

        // Backpressure: buffer fills, fetch stalls, one pop reopens it
        bus.ir_ready = 1'b0;
        do_reset(5);
        for (int a = 0; a < 3; a++) exp_q.push_back(ent(word_at(AW'(a)), AW'(a)));
        for (int c = 6; c <= 12; c++) begin
            run_to(c);
            chk_rd(1'b0, 9'd0);
            chk("ir_hold", ent(bus.IR, bus.ir_pc), ent(32'h0800_0000, 9'd0));
        end
        bus.ir_ready = 1'b1;
        run_to(13); bus.ir_ready = 1'b0;
        chk_ir(32'h0800_0001, 9'd1); chk_rd(1'b0, 9'd0);
        run_to(14); chk_rd(1'b1, 9'd2);
        bus.ir_ready = 1'b1;
        run_to(17); chk_drain();

        // Branch while a request is outstanding, L=3
        lat = 3;
        bus.ir_ready = 1'b1;
        do_reset(5);
        for (int a = 0; a < 5; a++) exp_q.push_back(ent(word_at(AW'(a)), AW'(a)));
        exp_q.push_back(ent(word_at(9'h040), 9'h040));
        run_to(6);  chk_rd(1'b1, 9'd1);
        run_to(26); chk_rd(1'b1, 9'd5);
        run_to(27); bus.br_take = 1'b1; bus.br_target = 9'h040;
        run_to(28); bus.br_take = 1'b0;
        for (int c = 28; c <= 30; c++) begin
            run_to(c);
            chk_empty();
            chk_rd(1'b0, 9'd0);
        end
        run_to(31); chk_rd(1'b1, 9'h040);
        run_to(35); chk_ir(32'h0800_0040, 9'h040);
        run_to(36); chk_drain();

        // Branch coincident with mem_valid and a pop
        lat = 1;
        bus.ir_ready = 1'b0;
        do_reset(5);
        exp_q.push_back(ent(word_at(9'd0), 9'd0));
        exp_q.push_back(ent(word_at(9'h010), 9'h010));
        run_to(5); chk_ir(32'h0800_0000, 9'd0);
        bus.ir_ready = 1'b1; bus.br_take = 1'b1; bus.br_target = 9'h010;
        run_to(6); bus.br_take = 1'b0;
        chk_empty(); chk_rd(1'b0, 9'd0);
        run_to(7); chk_rd(1'b1, 9'h010);
        run_to(9); chk_ir(32'h0800_0010, 9'h010);
        run_to(10); chk_drain();

        // HALT word at addr 3, then branch back to 0
        halt_en = 1'b1;
        lat = 1;
        bus.ir_ready = 1'b1;
        do_reset(5);
        for (int a = 0; a < 4; a++) exp_q.push_back(ent(word_at(AW'(a)), AW'(a)));
        exp_q.push_back(ent(word_at(9'd0), 9'd0));
        run_to(10); chk_rd(1'b1, 9'd3);
        run_to(11); chk("halted_pre", 64'(bus.halted), 64'd0);
        run_to(12); chk_ir(32'hF800_0000, 9'd3);
        chk("halted", 64'(bus.halted), 64'd1);
        for (int c = 13; c <= 32; c++) begin
            run_to(c);
            chk_rd(1'b0, 9'd0);
            chk("halted_hold", 64'(bus.halted), 64'd1);
        end
        run_to(33); bus.br_take = 1'b1; bus.br_target = 9'd0;
        run_to(34); bus.br_take = 1'b0;
        chk("halted_clr", 64'(bus.halted), 64'd0); chk_rd(1'b0, 9'd0); chk_empty();
        run_to(35); chk_rd(1'b1, 9'd0);
        run_to(37); chk_ir(32'h0800_0000, 9'd0);
        run_to(38); chk_drain();
        halt_en = 1'b0;

        // Reset mid-request; stale response lands in the first cycle after release
        lat = 3;
        bus.ir_ready = 1'b1;
        do_reset(5);
        exp_q.push_back(ent(word_at(9'd0), 9'd0));
        run_to(1); chk_rd(1'b1, 9'd0);
        run_to(2);
        clr = 1'b1;
        #1;
        chk_rd(1'b0, 9'd0); chk_empty();
        chk("clr_halted", 64'(bus.halted), 64'd0);
        tick(); chk_rd(1'b0, 9'd0);
        tick();
        clr = 1'b0;
        cyc = 0;
        chk_empty(); chk_rd(1'b0, 9'd0);
        run_to(1); chk_rd(1'b1, 9'd0);
        for (int c = 2; c <= 4; c++) begin
            run_to(c);
            chk_empty();
        end
        run_to(5); chk_ir(32'h0800_0000, 9'd0);
        run_to(6); chk_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
